// File: rtl/fft_frame_packer_if.sv
// fft_frame_packer_if: groups the FIR-side input stream, the FFT-side output
// stream with its ready handshake, and the sticky overflow flag.
// The packer drives the FFT stream, so it takes the master modport; the
// environment (FIR source plus FFT sink) takes the slave modport.
interface fft_frame_packer_if;
   logic signed [36:0] data_in;
   logic               data_valid;
   logic signed [15:0] fft_data;
   logic               fft_valid;
   logic               fft_sop;
   logic               fft_eop;
   logic               fft_ready;
   logic               overflow;

   modport master (
      input  data_in, data_valid, fft_ready,
      output fft_data, fft_valid, fft_sop, fft_eop, overflow
   );

   modport slave (
      output data_in, data_valid, fft_ready,
      input  fft_data, fft_valid, fft_sop, fft_eop, overflow
   );
endinterface

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: scales 37-bit FIR samples down to 16 bits with
// round-half-up, buffers them in a FIFO and emits whole frames of FRAME_LEN
// samples to an FFT with sop/eop framing and a valid/ready handshake.
// A frame is only started once it is completely buffered, so valid never
// gaps inside a frame.
// Optional feature: define FFT_PACK_SAT_EN to saturate the scaled value to
// the 16-bit range; without it the value wraps (low 16 bits kept).
module fft_frame_packer #(
   parameter int FRAME_LEN  = 1024,
   parameter int SHIFT      = 12,
   parameter int FIFO_DEPTH = 2048
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_frame_packer_if.master  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FRAME_LEN);
   localparam logic [AW:0]           FRAME_LEN_C = (AW+1)'(FRAME_LEN);
   localparam logic [AW:0]           DEPTH_C     = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]         LAST_IDX    = CW'(FRAME_LEN - 1);
   localparam logic signed [37:0]    ROUND       = 38'sd1 <<< (SHIFT - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [1:0]         rst_sync;
   logic               run;
   logic signed [37:0] widened;
   logic signed [37:0] rounded;
   logic signed [37:0] scaled;
   logic signed [15:0] narrowed;
   logic signed [15:0] scale_q;
   logic               scale_vld_q;
   logic signed [15:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic               full;
   logic               valid;
   logic               rd_en;
   logic               wr_en;
   logic               drop;
   logic [CW-1:0]      idx;
   logic               overflow_q;

   // Reset release is re-timed through two flops so the datapath only starts
   // accepting samples a couple of edges after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run = rst_sync[1];

   // Round-half-up and arithmetic shift in 38-bit signed arithmetic, then
   // narrow to 16 bits (saturating or wrapping depending on the build).
   always_comb begin
      widened  = {bus.data_in[36], bus.data_in};
      rounded  = widened + ROUND;
      scaled   = rounded >>> SHIFT;
`ifdef FFT_PACK_SAT_EN
      if (scaled > 38'sd32767)       narrowed = 16'sh7FFF;
      else if (scaled < -38'sd32768) narrowed = 16'sh8000;
      else                           narrowed = scaled[15:0];
`else
      narrowed = scaled[15:0];
`endif
   end

   // Single pipeline register holding the scaled sample and its valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale_q     <= '0;
         scale_vld_q <= 1'b0;
      end else begin
         scale_q     <= narrowed;
         scale_vld_q <= bus.data_valid & run;
      end
   end

   assign full  = (occ == DEPTH_C);
   assign valid = (state_q == SEND);
   assign rd_en = valid & bus.fft_ready;
   assign wr_en = scale_vld_q & (~full | rd_en);
   assign drop  = scale_vld_q & full & ~rd_en;

   // Sample storage; a write into a full FIFO only happens when the slot at
   // rd_ptr is being consumed in the same cycle.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= scale_q;
   end

   // FIFO pointers and occupancy; simultaneous read and write keep occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Sticky overflow: set whenever a sample is discarded, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Start a frame once a full frame is buffered; leave on the eop transfer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (occ >= FRAME_LEN_C) state_d = SEND;
         SEND: if (rd_en && (idx == LAST_IDX)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Position within the current frame, advanced on every transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     idx <= '0;
      else if (rd_en) idx <= (idx == LAST_IDX) ? '0 : idx + CW'(1);
   end

   assign bus.fft_valid = valid;
   assign bus.fft_data  = valid ? mem[rd_ptr] : '0;
   assign bus.fft_sop   = valid & (idx == '0);
   assign bus.fft_eop   = valid & (idx == LAST_IDX);
   assign bus.overflow  = overflow_q;

endmodule

// File: doc/fft_frame_packer.md
FFT_FRAME_PACKER -- requirements
Module: fft_frame_packer

Interface
REQ-001 Parameter FRAME_LEN, default 1024: number of samples per FFT frame; power of two, range 8..4096.
REQ-002 Parameter SHIFT, default 12: arithmetic right-shift applied to FIR output before narrowing; range 1..21.
REQ-003 Parameter FIFO_DEPTH, default 2048: sample buffer depth; power of two, at least FRAME_LEN.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 data_in  input  37  signed two's-complement FIR output sample.
REQ-007 data_valid  input  1  data_in is valid this cycle; there is no backpressure to the FIR.
REQ-008 fft_data  output  16  signed scaled sample to the FFT.
REQ-009 fft_valid  output  1  fft_data is valid.
REQ-010 fft_sop  output  1  first sample of a frame; qualified by fft_valid.
REQ-011 fft_eop  output  1  last sample of a frame; qualified by fft_valid.
REQ-012 fft_ready  input  1  FFT accepts the sample this cycle.
REQ-013 overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-014 Scale stage, one register, 1-cycle latency: s = (data_in + 2^(SHIFT-1)) >>> SHIFT, computed in 38-bit signed arithmetic.
REQ-015 The scale stage SHALL then narrow s to 16 bits as defined in the Configuration section.
REQ-016 A scaled sample SHALL be written to the FIFO in the cycle after its data_valid, if the FIFO has space or a read occurs in that same cycle.
REQ-017 A sample arriving when the FIFO is full and no read occurs SHALL be discarded, and overflow SHALL be set; overflow is cleared only by reset.
REQ-018 A transfer occurs when fft_valid and fft_ready are both 1; fft_data, fft_sop and fft_eop SHALL hold stable while fft_valid=1 and fft_ready=0.
REQ-019 FSM states are IDLE and SEND; reset state is IDLE.
REQ-020 IDLE->SEND when FIFO occupancy >= FRAME_LEN; fft_valid rises with the first sample no later than 2 cycles after the occupancy condition is met.
REQ-021 In SEND, fft_valid SHALL stay 1 from the first sample through the last, with no gaps, because a whole frame is buffered before SEND is entered.
REQ-022 A sample counter runs 0..FRAME_LEN-1: fft_sop=1 at index 0 and fft_eop=1 at index FRAME_LEN-1.
REQ-023 The transfer at index FRAME_LEN-1 returns the FSM to IDLE and resets the counter to 0.
REQ-024 Back-to-back frames: if occupancy is still >= FRAME_LEN after eop, the next sop SHALL be presented within 2 cycles.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; a simultaneous read and write SHALL leave occupancy unchanged.
REQ-026 Occupancy SHALL never exceed FIFO_DEPTH or underflow.
REQ-027 fft_valid=0 SHALL imply fft_sop=0 and fft_eop=0.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear the following, without waiting for a clock edge:
- FIFO pointers and occupancy;
- the sample counter and the scale register;
- FSM state, set to IDLE;
- outputs fft_data=0, fft_valid=0, fft_sop=0, fft_eop=0, overflow=0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial frame; the first frame after reset starts with fft_sop=1 at index 0.
REQ-030 Reset release SHALL be synchronised internally, so that the first write occurs no earlier than the second clock edge after rst_n rises.

Configuration
REQ-031 Macro FFT_PACK_SAT_EN defined: values s > 32767 SHALL give 32767 and values s < -32768 SHALL give -32768.
REQ-032 Macro FFT_PACK_SAT_EN undefined: fft_data SHALL be s[15:0] (two's-complement wrap), and no saturation logic SHALL be present.

Verification
REQ-033 FRAME_LEN=8, SHIFT=4, data_valid held high with ramp inputs 16*k, fft_ready=1 -> fft_data=k, sop on k=0, eop on k=7, no fft_valid gaps within the frame.
REQ-034 data_in=24, SHIFT=4 -> 2 (round half up); data_in=-24 -> -1; data_in=8 -> 1; data_in=7 -> 0.
REQ-035 data_in=2^30, SHIFT=4 -> 32767 with FFT_PACK_SAT_EN defined; 0 without it. data_in=-2^30 -> -32768 with the macro; 0 without it.
REQ-036 FIFO_DEPTH=16, FRAME_LEN=8, fft_ready=0, 20 valid samples -> 16 samples stored and overflow=1; after releasing fft_ready, two complete frames are output.
REQ-037 fft_ready toggled 1/0 every cycle during a frame -> each sample is transferred exactly once, and outputs hold stable while stalled.
REQ-038 rst_n pulsed low at index 3 of a frame -> all outputs 0 immediately; after release and 8 new samples, a fresh frame starts with sop.
